// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants and types for the timer APB register block
package timer_pkg;

  // Register addresses
  localparam logic [7:0] ADDR_TDR = 8'h00;
  localparam logic [7:0] ADDR_TCR = 8'h01;
  localparam logic [7:0] ADDR_TSR = 8'h02;

  // Writable / readable bit masks per register
  localparam logic [7:0] TDR_MASK = 8'hFF;
  localparam logic [7:0] TCR_MASK = 8'hB3;
  localparam logic [7:0] TSR_MASK = 8'h03;

  // TCR field positions
  localparam int TCR_LOAD   = 7;
  localparam int TCR_DN     = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_CKS_HI = 1;
  localparam int TCR_CKS_LO = 0;

  // APB completer handshake states
  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS,
    APB_WAIT
  } apb_state_e;

endpackage

// File: rtl/timer_apb_fsm.sv
// rtl/timer_apb_fsm.sv - APB handshake FSM with wait counter and pready/pslverr generation
module timer_apb_fsm
  import timer_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic psel,
  input  logic penable,
  input  logic addr_err_i,
  output logic pready_o,
  output logic pslverr_o,
  output logic done_o
);

  apb_state_e state_q;
  logic [2:0] cnt_q;
  logic       pready_q;
  logic       pslverr_q;
  logic       done_d;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  // Completion lookahead: high when the next cycle is the pready=1 cycle
  always_comb begin
    done_d = 1'b0;
    unique case (state_q)
      APB_SETUP:  done_d = psel && (WAIT_CYCLES == 0);
      APB_ACCESS,
      APB_WAIT:   done_d = psel && !pready_q && ((cnt_q + 3'd1) == WAIT_LAST);
      default:    done_d = 1'b0;
    endcase
  end

  // Handshake state, wait counter and registered pready/pslverr
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= APB_IDLE;
      cnt_q     <= 3'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= done_d;
      pslverr_q <= done_d && addr_err_i;
      unique case (state_q)
        APB_IDLE: begin
          cnt_q <= 3'd0;
          if (psel && !penable) state_q <= APB_SETUP;
        end
        APB_SETUP: begin
          cnt_q   <= 3'd0;
          state_q <= psel ? APB_ACCESS : APB_IDLE;
        end
        APB_ACCESS,
        APB_WAIT: begin
          if (pready_q) begin
            cnt_q   <= 3'd0;
            state_q <= (psel && !penable) ? APB_SETUP : APB_IDLE;
          end else if (!psel) begin
            cnt_q   <= 3'd0;
            state_q <= APB_IDLE;
          end else begin
            cnt_q   <= cnt_q + 3'd1;
            state_q <= APB_WAIT;
          end
        end
        default: begin
          cnt_q   <= 3'd0;
          state_q <= APB_IDLE;
        end
      endcase
    end
  end

  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign done_o    = done_d;

endmodule

// File: rtl/timer_apb_regs.sv
// rtl/timer_apb_regs.sv - APB completer holding TDR/TCR/TSR for the 8-bit timer
module timer_apb_regs
  import timer_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 8
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [7:0]        tdr_o,
  output logic              load_o,
  output logic              dn_o,
  output logic              en_o,
  output logic [1:0]        cks_o,
  input  logic              ovf_set_i,
  input  logic              udf_set_i
);

  logic [7:0] tdr_q, tdr_d;
  logic [7:0] tcr_q, tcr_d;
  logic [1:0] tsr_q, tsr_d;
  logic [7:0] prdata_q, prdata_d;
  logic [7:0] rdata;
  logic       hit_tdr, hit_tcr, hit_tsr, addr_err;
  logic       done;
  logic       wr_en;
  logic [1:0] w1c;

  assign hit_tdr  = (paddr == ADDR_W'(ADDR_TDR));
  assign hit_tcr  = (paddr == ADDR_W'(ADDR_TCR));
  assign hit_tsr  = (paddr == ADDR_W'(ADDR_TSR));
  assign addr_err = !(hit_tdr || hit_tcr || hit_tsr);

  timer_apb_fsm #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_fsm (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .psel       (psel),
    .penable    (penable),
    .addr_err_i (addr_err),
    .pready_o   (pready),
    .pslverr_o  (pslverr),
    .done_o     (done)
  );

  // Writes commit on the edge that ends the pready=1 cycle
  assign wr_en = pready && psel && penable && pwrite && !pslverr;
  assign w1c   = (wr_en && hit_tsr) ? (pwdata[1:0] & TSR_MASK[1:0]) : 2'b00;

  // Read mux with unimplemented bits returning zero
  always_comb begin
    rdata = 8'h00;
    if (hit_tdr)      rdata = tdr_q & TDR_MASK;
    else if (hit_tcr) rdata = tcr_q & TCR_MASK;
    else if (hit_tsr) rdata = {6'd0, tsr_q} & TSR_MASK;
  end

  // Next-state for registers; a hardware event beats a same-cycle W1C
  always_comb begin
    tdr_d    = tdr_q;
    tcr_d    = tcr_q;
    tsr_d    = (tsr_q & ~w1c) | {udf_set_i, ovf_set_i};
    prdata_d = (done && !pwrite && !addr_err) ? rdata : 8'h00;
    if (wr_en && hit_tdr) tdr_d = pwdata & TDR_MASK;
    if (wr_en && hit_tcr) tcr_d = pwdata & TCR_MASK;
  end

  // Register storage and registered read data
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      tdr_q    <= 8'h00;
      tcr_q    <= 8'h00;
      tsr_q    <= 2'b00;
      prdata_q <= 8'h00;
    end else begin
      tdr_q    <= tdr_d;
      tcr_q    <= tcr_d;
      tsr_q    <= tsr_d;
      prdata_q <= prdata_d;
    end
  end

  assign prdata = prdata_q;
  assign tdr_o  = tdr_q;
  assign load_o = tcr_q[TCR_LOAD];
  assign dn_o   = tcr_q[TCR_DN];
  assign en_o   = tcr_q[TCR_EN];
  assign cks_o  = tcr_q[TCR_CKS_HI:TCR_CKS_LO];

endmodule

// File: tb/tb_timer_apb_regs.sv
// tb/tb_timer_apb_regs.sv - self-checking bench for timer_apb_regs
module tb_timer_apb_regs;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic       psel_v    [2];
  logic       penable_v [2];
  logic       pwrite_v  [2];
  logic [7:0] paddr_v   [2];
  logic [7:0] pwdata_v  [2];
  logic       ovf_v     [2];
  logic       udf_v     [2];

  logic [7:0] prdata0, prdata3, tdr0, tdr3;
  logic       pready0, pready3, pslverr0, pslverr3;
  logic       load0, load3, dn0, dn3, en0, en3;
  logic [1:0] cks0, cks3;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    bit         is_read;
    logic [7:0] rdata;
    logic       err;
    int         lowcyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rd;
    logic       err;
    bit         chk_out;
    logic [7:0] tdr;
    logic [4:0] ctl;
  } vec_t;
  vec_t tbl[12];

  always #5 pclk = ~pclk;

  timer_apb_regs #(.WAIT_CYCLES(0), .ADDR_W(8)) dut0 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel_v[0]), .penable(penable_v[0]),
    .pwrite(pwrite_v[0]), .paddr(paddr_v[0]), .pwdata(pwdata_v[0]), .prdata(prdata0),
    .pready(pready0), .pslverr(pslverr0), .tdr_o(tdr0), .load_o(load0), .dn_o(dn0),
    .en_o(en0), .cks_o(cks0), .ovf_set_i(ovf_v[0]), .udf_set_i(udf_v[0])
  );

  timer_apb_regs #(.WAIT_CYCLES(3), .ADDR_W(8)) dut3 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel_v[1]), .penable(penable_v[1]),
    .pwrite(pwrite_v[1]), .paddr(paddr_v[1]), .pwdata(pwdata_v[1]), .prdata(prdata3),
    .pready(pready3), .pslverr(pslverr3), .tdr_o(tdr3), .load_o(load3), .dn_o(dn3),
    .en_o(en3), .cks_o(cks3), .ovf_set_i(ovf_v[1]), .udf_set_i(udf_v[1])
  );

  function automatic logic get_pready(input int w);
    return (w == 1) ? pready3 : pready0;
  endfunction

  function automatic logic get_pslverr(input int w);
    return (w == 1) ? pslverr3 : pslverr0;
  endfunction

  function automatic logic [7:0] get_prdata(input int w);
    return (w == 1) ? prdata3 : prdata0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_bus(input int w, input logic s, input logic e, input logic wr,
                         input logic [7:0] a, input logic [7:0] d);
    psel_v[w]    = s;
    penable_v[w] = e;
    pwrite_v[w]  = wr;
    paddr_v[w]   = a;
    pwdata_v[w]  = d;
  endtask

  // Idle one cycle; the cycle after a completion must show pready=0 and prdata=00
  task automatic idle(input int w);
    @(posedge pclk); #1;
    set_bus(w, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    ovf_v[w] = 1'b0;
    udf_v[w] = 1'b0;
    chk("pready one cycle", {31'd0, get_pready(w)}, 32'd0);
    chk("prdata idle zero", {24'd0, get_prdata(w)}, 32'd0);
  endtask

  task automatic pulse(input int w, input logic ovf, input logic udf);
    @(posedge pclk); #1;
    ovf_v[w] = ovf;
    udf_v[w] = udf;
    @(posedge pclk); #1;
    ovf_v[w] = 1'b0;
    udf_v[w] = 1'b0;
  endtask

  // One APB transfer; returns in the pready=1 cycle with the bus still in ACCESS
  task automatic apb(input int w, input bit wr, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd, input logic exp_err, input bit udf_at_done,
                     input string name);
    exp_t e;
    int   n;
    int   low;
    e.name    = name;
    e.is_read = !wr;
    e.rdata   = exp_rd;
    e.err     = exp_err;
    e.lowcyc  = (w == 1) ? 4 : 1;
    sb.push_back(e);
    @(posedge pclk); #1;
    ovf_v[w] = 1'b0;
    udf_v[w] = 1'b0;
    set_bus(w, 1'b1, 1'b0, wr, a, d);
    @(posedge pclk); #1;
    penable_v[w] = 1'b1;
    n   = 0;
    low = 0;
    while (!get_pready(w) && n < 20) begin
      low++;
      @(posedge pclk); #1;
      n++;
    end
    e = sb.pop_front();
    if (!get_pready(w)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: pready got 0 expected 1", e.name);
    end else begin
      chk({e.name, " pslverr"}, {31'd0, get_pslverr(w)}, {31'd0, e.err});
      if (e.is_read) chk({e.name, " prdata"}, {24'd0, get_prdata(w)}, {24'd0, e.rdata});
      chk({e.name, " wait cycles"}, low, e.lowcyc);
      if (udf_at_done) udf_v[w] = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {wr, addr, wdata, exp rdata, exp err, check outputs, exp tdr, exp {load,dn,en,cks}}
    tbl[0]  = '{1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF, 5'b0_0_0_00};
    tbl[1]  = '{1'b1, 8'h01, 8'h81, 8'h00, 1'b0, 1'b1, 8'hFF, 5'b1_0_0_01};
    tbl[2]  = '{1'b1, 8'h01, 8'h31, 8'h00, 1'b0, 1'b1, 8'hFF, 5'b0_1_1_01};
    tbl[3]  = '{1'b0, 8'h01, 8'h00, 8'h31, 1'b0, 1'b0, 8'h00, 5'b0_0_0_00};
    tbl[4]  = '{1'b1, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF, 5'b1_1_1_11};
    tbl[5]  = '{1'b0, 8'h01, 8'h00, 8'hB3, 1'b0, 1'b0, 8'h00, 5'b0_0_0_00};
    tbl[6]  = '{1'b1, 8'h02, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 5'b0_0_0_00};
    tbl[7]  = '{1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 5'b0_0_0_00};
    tbl[8]  = '{1'b1, 8'h05, 8'hAA, 8'h00, 1'b1, 1'b1, 8'hFF, 5'b1_1_1_11};
    tbl[9]  = '{1'b0, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 5'b0_0_0_00};
    tbl[10] = '{1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 5'b0_0_0_00};
    tbl[11] = '{1'b0, 8'h01, 8'h00, 8'hB3, 1'b0, 1'b0, 8'h00, 5'b0_0_0_00};

    preset_n = 1'b0;
    for (int w = 0; w < 2; w++) begin
      set_bus(w, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      ovf_v[w] = 1'b0;
      udf_v[w] = 1'b0;
    end
    repeat (2) @(posedge pclk);
    #1;
    chk("reset pready", {31'd0, pready0}, 32'd0);
    chk("reset pslverr", {31'd0, pslverr0}, 32'd0);
    chk("reset prdata", {24'd0, prdata0}, 32'd0);
    chk("reset tdr_o", {24'd0, tdr0}, 32'd0);
    chk("reset ctl", {27'd0, load0, dn0, en0, cks0}, 32'd0);
    chk("reset pready w3", {31'd0, pready3}, 32'd0);
    preset_n = 1'b1;

    // Load nonzero state, then reset in the middle of an ACCESS phase
    apb(0, 1'b1, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b0, "pre tdr");
    idle(0);
    apb(0, 1'b1, 8'h01, 8'hB3, 8'h00, 1'b0, 1'b0, "pre tcr");
    idle(0);
    chk("pre tdr_o", {24'd0, tdr0}, 32'h5A);
    @(posedge pclk); #1;
    set_bus(0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h77);
    @(posedge pclk); #1;
    penable_v[0] = 1'b1;
    #2;
    preset_n = 1'b0;
    #1;
    chk("async rst tdr_o", {24'd0, tdr0}, 32'd0);
    chk("async rst ctl", {27'd0, load0, dn0, en0, cks0}, 32'd0);
    chk("async rst pready", {31'd0, pready0}, 32'd0);
    set_bus(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge pclk); #1;
    preset_n = 1'b1;
    apb(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "post rst TDR");
    idle(0);
    apb(0, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, "post rst TCR");
    idle(0);
    apb(0, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0, "post rst TSR");
    idle(0);

    // Table-driven register access
    for (int i = 0; i < 12; i++) begin
      apb(0, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].err, 1'b0,
          $sformatf("vec%0d", i));
      idle(0);
      if (tbl[i].chk_out) begin
        chk($sformatf("vec%0d tdr_o", i), {24'd0, tdr0}, {24'd0, tbl[i].tdr});
        chk($sformatf("vec%0d ctl", i), {27'd0, load0, dn0, en0, cks0}, {27'd0, tbl[i].ctl});
      end
    end

    // Sticky flags with write-1-to-clear
    pulse(0, 1'b0, 1'b1);
    apb(0, 1'b0, 8'h02, 8'h00, 8'h02, 1'b0, 1'b0, "udf set");
    idle(0);
    apb(0, 1'b1, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0, "w1c ovf only");
    idle(0);
    apb(0, 1'b0, 8'h02, 8'h00, 8'h02, 1'b0, 1'b0, "udf kept");
    idle(0);
    apb(0, 1'b1, 8'h02, 8'h02, 8'h00, 1'b0, 1'b0, "w1c udf");
    idle(0);
    apb(0, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0, "udf cleared");
    idle(0);
    apb(0, 1'b1, 8'h02, 8'h02, 8'h00, 1'b0, 1'b1, "w1c vs set");
    idle(0);
    apb(0, 1'b0, 8'h02, 8'h00, 8'h02, 1'b0, 1'b0, "set wins");
    idle(0);
    apb(0, 1'b1, 8'h02, 8'h02, 8'h00, 1'b0, 1'b0, "w1c udf again");
    idle(0);
    pulse(0, 1'b1, 1'b0);
    apb(0, 1'b0, 8'h02, 8'h00, 8'h01, 1'b0, 1'b0, "ovf set");
    idle(0);
    apb(0, 1'b1, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0, "w1c ovf");
    idle(0);
    apb(0, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0, "ovf cleared");
    idle(0);

    // Wait-state instance: back-to-back write then read
    apb(1, 1'b1, 8'h00, 8'h12, 8'h00, 1'b0, 1'b0, "w3 write");
    apb(1, 1'b0, 8'h00, 8'h00, 8'h12, 1'b0, 1'b0, "w3 read b2b");
    idle(1);
    apb(1, 1'b0, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, "w3 bad addr");
    idle(1);
    chk("w3 tdr_o", {24'd0, tdr3}, 32'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_apb_regs.md
Name: timer_apb_regs

Overview:
APB completer (responder) for the 8-bit timer. It answers the CPU-side APB initiator, holds the TDR, TCR and TSR registers, and drives the control fields to the counter core. It also captures overflow/underflow events from the core into TSR sticky flags. It sits between the APB bus and the timer counter, inside the timer top.

Parameters:
- WAIT_CYCLES, 0: number of extra ACCESS cycles with pready low before completion; legal range 0..7.
- ADDR_W, 8: paddr width.

Ports:
- pclk  in  1  APB/system clock; single clock domain.
- preset_n  in  1  asynchronous, active-low reset.
- psel  in  1  completer select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  register address.
- pwdata  in  8  write data.
- prdata  out  8  read data; valid when pready=1 in ACCESS.
- pready  out  1  transfer complete.
- pslverr  out  1  error response; valid only with pready.
- tdr_o  out  8  TDR value (reload value) to counter.
- load_o  out  1  TCR[7]; load TDR into counter.
- dn_o  out  1  TCR[5]; 1 = count down, 0 = count up.
- en_o  out  1  TCR[4]; counter enable.
- cks_o  out  2  TCR[1:0]; 00 = pclk/2, 01 = pclk/4, 10 = pclk/8, 11 = pclk/16.
- ovf_set_i  in  1  one-cycle pulse from core on overflow (FF->00 counting up).
- udf_set_i  in  1  one-cycle pulse from core on underflow (00->FF counting down).

Behaviour:
- Reset (asynchronous, preset_n=0): TDR=00, TCR=00, TSR=00, prdata=00, pready=0, pslverr=0, FSM=IDLE, wait counter=0. All outputs return to these values immediately, including mid-transfer; the aborted transfer has no register effect.
- Register map:
  - 0x00 TDR: RW, all 8 bits writable (mask FF).
  - 0x01 TCR: RW, mask B3 (bits 7,5,4,1,0). Bits 6,3,2 ignore writes and read 0.
  - 0x02 TSR: mask 03. Bit1 = UDF, bit0 = OVF. Write-1-to-clear; writing 0 has no effect. Bits 7:2 read 0.
  - Any other address: pslverr=1 with pready, no register change, prdata=00.
- FSM states: IDLE, SETUP, ACCESS, WAIT.
  - IDLE -> SETUP when psel=1 and penable=0.
  - SETUP -> ACCESS next cycle. If WAIT_CYCLES=0, pready=1 in the first ACCESS cycle.
  - Otherwise ACCESS -> WAIT, with a counter running to WAIT_CYCLES; pready=1 on the final cycle.
  - On the pready=1 cycle, the next state is SETUP if psel=1 and penable=0 (back-to-back), else IDLE.
  - If psel drops before completion, return to IDLE with no effect.
  - Address, pwrite and pwdata are sampled at completion; the initiator holds them stable per APB.
- Write commit: register updates on the pclk edge ending the pready=1 cycle. Outputs reflect the new value the following cycle.
- Read: prdata is registered and presented in the pready=1 cycle. prdata=00 whenever pready=0.
- pready and pslverr are registered and asserted for exactly one cycle per transfer.
- TSR flags: set on ovf_set_i/udf_set_i; each stays set until software clears it. If a hardware set and a software W1C hit the same bit in the same cycle, set wins.
- load_o is a level, held until software rewrites TCR with bit7=0; no self-clear.
- TCR output fields map directly to register bits; TCR writes take effect the cycle after commit.
- A TDR write does not itself load the counter.

Decomposition:
- Package timer_pkg holds:
  - Address constants ADDR_TDR=00, ADDR_TCR=01, ADDR_TSR=02.
  - Masks TDR_MASK=FF, TCR_MASK=B3, TSR_MASK=03.
  - TCR bit indices LOAD=7, DN=5, EN=4, CKS=1:0.
  - APB FSM state enum.
- One natural sub-module: timer_apb_fsm, covering the handshake FSM, wait counter and pready/pslverr generation.
- Register storage and decode stay in timer_apb_regs.

Test Plan:
- Reset: preset_n low mid-ACCESS -> all outputs 00/0 immediately; a read of 0x00, 0x01, 0x02 after release returns 00, 00, 00.
- Write TDR=FF then TCR=81 (0x01<-8'b1000_0001) -> tdr_o=FF, load_o=1, en_o=0, cks_o=01; then write TCR=31 -> load_o=0, dn_o=1, en_o=1, cks_o=01; read 0x01 returns 31.
- Mask check: write TCR=FF -> read 0x01 returns B3; write TSR=FF with no events -> read 0x02 returns 00.
- Flags: pulse udf_set_i -> read 0x02 = 02; write 0x02<-01 -> still 02; write 02 -> 00. Pulse udf_set_i in the same cycle as the W1C commit of 02 -> reads 02.
- Invalid address: write 0x05<-AA -> pslverr=1 with pready, TDR/TCR/TSR unchanged; read 0x05 -> prdata=00, pslverr=1.
- WAIT_CYCLES=3: each transfer has pready low for 3 ACCESS cycles, then high for 1. Back-to-back write 0x00<-12 and read 0x00 -> read returns 12.
